// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for the pipelined MIPS core.
// Tracks DEPTH post-decode slots, picks each decode operand from the youngest producer, and owns the ID/EX operand register.
module hazard_forward_unit #(
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5,
    parameter int DEPTH     = 3,
    parameter int LOAD_SLOT = 2,
    parameter int FWD_EN    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic [DATA_W-1:0] id_rdata1,
    input  logic [DATA_W-1:0] id_rdata2,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              flush,
    output logic              stall,
    output logic [DATA_W-1:0] ex_op1,
    output logic [DATA_W-1:0] ex_op2,
    output logic              ex_valid,
    output logic [15:0]       stall_cnt
);

    logic              valid_r [DEPTH];
    logic [REG_AW-1:0] dest_r  [DEPTH];
    logic              wb_en_r [DEPTH];
    logic              load_r  [DEPTH];
    logic              ready_r [DEPTH];
    logic [DATA_W-1:0] data_r  [DEPTH];

    logic              eff_ready_s [DEPTH];
    logic [DATA_W-1:0] eff_data_s  [DEPTH];
    logic [DEPTH-1:0]  match1_s;
    logic [DEPTH-1:0]  match2_s;
    logic              hit1_s;
    logic              hit2_s;
    logic              rdy1_s;
    logic              rdy2_s;
    logic [DATA_W-1:0] op1_s;
    logic [DATA_W-1:0] op2_s;
    logic              hazard1_s;
    logic              hazard2_s;
    logic              stall_s;
    logic              issue_s;

    logic [DATA_W-1:0] ex_op1_r;
    logic [DATA_W-1:0] ex_op2_r;
    logic [15:0]       stall_cnt_r;

    // Effective slot view: slot 0 ALU results and the load in the memory-read slot come straight off the live buses.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            if ((i == 0) && !load_r[i]) begin
                eff_ready_s[i] = 1'b1;
                eff_data_s[i]  = ex_result;
            end else if ((i == LOAD_SLOT - 1) && load_r[i]) begin
                eff_ready_s[i] = 1'b1;
                eff_data_s[i]  = mem_rdata;
            end else begin
                eff_ready_s[i] = ready_r[i];
                eff_data_s[i]  = data_r[i];
            end
        end
    end

    // Per-slot producer matches for both decode sources; register 0 never matches.
    always_comb begin
        match1_s = {DEPTH{1'b0}};
        match2_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            match1_s[i] = valid_r[i] & wb_en_r[i] & (dest_r[i] == id_src1)
                        & (id_src1 != {REG_AW{1'b0}});
            match2_s[i] = valid_r[i] & wb_en_r[i] & (dest_r[i] == id_src2)
                        & (id_src2 != {REG_AW{1'b0}}) & id_src2_used;
        end
    end

    // Priority pick: scan oldest to youngest so the lowest matching index overwrites everything older.
    always_comb begin
        hit1_s = 1'b0;
        hit2_s = 1'b0;
        rdy1_s = 1'b0;
        rdy2_s = 1'b0;
        op1_s  = id_rdata1;
        op2_s  = id_rdata2;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            hit1_s = hit1_s | match1_s[i];
            rdy1_s = match1_s[i] ? eff_ready_s[i] : rdy1_s;
            op1_s  = match1_s[i] ? eff_data_s[i]  : op1_s;
            hit2_s = hit2_s | match2_s[i];
            rdy2_s = match2_s[i] ? eff_ready_s[i] : rdy2_s;
            op2_s  = match2_s[i] ? eff_data_s[i]  : op2_s;
        end
    end

    assign hazard1_s = hit1_s & ((FWD_EN != 0) ? ~rdy1_s : 1'b1);
    assign hazard2_s = hit2_s & ((FWD_EN != 0) ? ~rdy2_s : 1'b1);
    assign stall_s   = (hazard1_s | hazard2_s) & id_valid & ~flush;
    assign issue_s   = id_valid & ~stall_s & ~flush;

    // Slot pipeline: decode or a bubble enters slot 0, everything else shifts one slot older.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                dest_r[i]  <= {REG_AW{1'b0}};
                wb_en_r[i] <= 1'b0;
                load_r[i]  <= 1'b0;
                ready_r[i] <= 1'b0;
                data_r[i]  <= {DATA_W{1'b0}};
            end
        end else begin
            valid_r[0] <= issue_s;
            dest_r[0]  <= id_dest;
            wb_en_r[0] <= id_wb_en;
            load_r[0]  <= id_mem_r_en;
            ready_r[0] <= 1'b0;
            data_r[0]  <= {DATA_W{1'b0}};
            for (int i = 1; i < DEPTH; i++) begin
                valid_r[i] <= valid_r[i-1];
                dest_r[i]  <= dest_r[i-1];
                wb_en_r[i] <= wb_en_r[i-1];
                load_r[i]  <= load_r[i-1];
                ready_r[i] <= eff_ready_s[i-1];
                data_r[i]  <= eff_data_s[i-1];
            end
        end
    end

    // ID/EX operand register; holds its old contents on a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_op1_r <= {DATA_W{1'b0}};
            ex_op2_r <= {DATA_W{1'b0}};
        end else if (issue_s) begin
            ex_op1_r <= op1_s;
            ex_op2_r <= op2_s;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= 16'h0000;
        end else if (stall_s && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'h0001;
        end
    end

    assign stall     = stall_s;
    assign ex_op1    = ex_op1_r;
    assign ex_op2    = ex_op2_r;
    assign ex_valid  = valid_r[0];
    assign stall_cnt = stall_cnt_r;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench for hazard_forward_unit: a forwarding instance and a no-forward instance driven by directed
// instruction sequences, checked every cycle against an instruction-age model plus literal expectations.
module tb_hazard_forward_unit;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int D  = 3;
    localparam int LS = 2;
    localparam logic [DW-1:0] JUNK_EX  = 32'hDEAD_BEEF;
    localparam logic [DW-1:0] JUNK_MEM = 32'hBAD0_C0DE;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic          wb;
        logic          ld;
        logic [DW-1:0] value;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          id_valid [2];
    logic [AW-1:0] id_src1 [2];
    logic [AW-1:0] id_src2 [2];
    logic          id_src2_used [2];
    logic [AW-1:0] id_dest [2];
    logic          id_wb_en [2];
    logic          id_mem_r_en [2];
    logic [DW-1:0] id_rdata1 [2];
    logic [DW-1:0] id_rdata2 [2];
    logic [DW-1:0] ex_result [2];
    logic [DW-1:0] mem_rdata [2];
    logic          flush [2];
    logic          stall [2];
    logic [DW-1:0] ex_op1 [2];
    logic [DW-1:0] ex_op2 [2];
    logic          ex_valid [2];
    logic [15:0]   stall_cnt [2];
    logic [DW-1:0] id_value [2];

    rec_t          pipe [2][D];
    logic          exp_stall [2];
    logic          exp_valid [2];
    logic          acc [2];
    logic [DW-1:0] exp_op1 [2];
    logic [DW-1:0] exp_op2 [2];
    logic [DW-1:0] nxt_op1 [2];
    logic [DW-1:0] nxt_op2 [2];
    int            exp_cnt [2];

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;
    int ns;

    always #5 clk = ~clk;

    hazard_forward_unit #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .LOAD_SLOT(LS), .FWD_EN(1)) dut_fwd (
        .clk(clk), .rst(rst), .id_valid(id_valid[0]), .id_src1(id_src1[0]), .id_src2(id_src2[0]),
        .id_src2_used(id_src2_used[0]), .id_dest(id_dest[0]), .id_wb_en(id_wb_en[0]),
        .id_mem_r_en(id_mem_r_en[0]), .id_rdata1(id_rdata1[0]), .id_rdata2(id_rdata2[0]),
        .ex_result(ex_result[0]), .mem_rdata(mem_rdata[0]), .flush(flush[0]), .stall(stall[0]),
        .ex_op1(ex_op1[0]), .ex_op2(ex_op2[0]), .ex_valid(ex_valid[0]), .stall_cnt(stall_cnt[0])
    );

    hazard_forward_unit #(.DATA_W(DW), .REG_AW(AW), .DEPTH(D), .LOAD_SLOT(LS), .FWD_EN(0)) dut_nofwd (
        .clk(clk), .rst(rst), .id_valid(id_valid[1]), .id_src1(id_src1[1]), .id_src2(id_src2[1]),
        .id_src2_used(id_src2_used[1]), .id_dest(id_dest[1]), .id_wb_en(id_wb_en[1]),
        .id_mem_r_en(id_mem_r_en[1]), .id_rdata1(id_rdata1[1]), .id_rdata2(id_rdata2[1]),
        .ex_result(ex_result[1]), .mem_rdata(mem_rdata[1]), .flush(flush[1]), .stall(stall[1]),
        .ex_op1(ex_op1[1]), .ex_op2(ex_op2[1]), .ex_valid(ex_valid[1]), .stall_cnt(stall_cnt[1])
    );

    task automatic chk(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s unit%0d: got 0x%08h expected 0x%08h", name, u, act, exp);
        end
    endtask

    // Youngest in-flight writer of s decides; it is usable once old enough to have produced its result.
    task automatic lookup(input int u, input logic [AW-1:0] s, input logic used,
                          input logic [DW-1:0] rdata, output logic haz, output logic [DW-1:0] op);
        bit found;
        int need;
        haz = 1'b0;
        op = rdata;
        found = 1'b0;
        for (int age = 0; age < D; age++) begin
            if (!found && pipe[u][age].valid && pipe[u][age].wb && pipe[u][age].dest == s
                && s != 5'd0 && used) begin
                found = 1'b1;
                op = pipe[u][age].value;
                need = pipe[u][age].ld ? LS - 1 : 0;
                haz = !((u == 0) && (age >= need));
            end
        end
    endtask

    task automatic calc();
        logic h1, h2;
        logic [DW-1:0] o1, o2;
        for (int u = 0; u < 2; u++) begin
            ex_result[u] = (pipe[u][0].valid && !pipe[u][0].ld) ? pipe[u][0].value : JUNK_EX;
            mem_rdata[u] = (pipe[u][LS-1].valid && pipe[u][LS-1].ld) ? pipe[u][LS-1].value : JUNK_MEM;
            lookup(u, id_src1[u], 1'b1, id_rdata1[u], h1, o1);
            lookup(u, id_src2[u], id_src2_used[u], id_rdata2[u], h2, o2);
            exp_stall[u] = (h1 || h2) && id_valid[u] && !flush[u];
            acc[u] = id_valid[u] && !flush[u] && !exp_stall[u];
            nxt_op1[u] = o1;
            nxt_op2[u] = o2;
        end
    endtask

    task automatic advance();
        rec_t r;
        for (int u = 0; u < 2; u++) begin
            if (exp_stall[u] && exp_cnt[u] < 65535) exp_cnt[u]++;
            r = '0;
            exp_valid[u] = acc[u];
            if (acc[u]) begin
                r.valid = 1'b1;
                r.dest = id_dest[u];
                r.wb = id_wb_en[u];
                r.ld = id_mem_r_en[u];
                r.value = id_value[u];
                exp_op1[u] = nxt_op1[u];
                exp_op2[u] = nxt_op2[u];
            end
            for (int k = D - 1; k > 0; k--) pipe[u][k] = pipe[u][k-1];
            pipe[u][0] = r;
        end
    endtask

    task automatic model_reset();
        for (int u = 0; u < 2; u++) begin
            for (int k = 0; k < D; k++) pipe[u][k] = '0;
            exp_stall[u] = 1'b0;
            exp_valid[u] = 1'b0;
            acc[u] = 1'b0;
            exp_op1[u] = 32'd0;
            exp_op2[u] = 32'd0;
            exp_cnt[u] = 0;
        end
    endtask

    task automatic tick();
        calc();
        @(posedge clk);
        #1;
        advance();
    endtask

    task automatic idle(input int n);
        id_valid[0] = 1'b0;
        id_valid[1] = 1'b0;
        repeat (n) tick();
    endtask

    task automatic issue(input int u, input logic [AW-1:0] s1, input logic [AW-1:0] s2, input logic used,
                         input logic [AW-1:0] d, input logic wb, input logic ld,
                         input logic [DW-1:0] rd1, input logic [DW-1:0] rd2, input logic [DW-1:0] val,
                         output int nstall);
        bit took;
        bit done;
        id_valid[u] = 1'b1;
        id_src1[u] = s1;
        id_src2[u] = s2;
        id_src2_used[u] = used;
        id_dest[u] = d;
        id_wb_en[u] = wb;
        id_mem_r_en[u] = ld;
        id_rdata1[u] = rd1;
        id_rdata2[u] = rd2;
        id_value[u] = val;
        nstall = 0;
        done = 1'b0;
        for (int k = 0; k < 16 && !done; k++) begin
            calc();
            took = acc[u];
            @(posedge clk);
            #1;
            advance();
            if (took) done = 1'b1;
            else nstall++;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL issue_timeout unit%0d: got no accept expected accept within 16 cycles", u);
        end
        id_valid[u] = 1'b0;
    endtask

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int u = 0; u < 2; u++) begin
                chk("stall", u, {31'd0, stall[u]}, {31'd0, exp_stall[u]});
                chk("ex_valid", u, {31'd0, ex_valid[u]}, {31'd0, exp_valid[u]});
                chk("ex_op1", u, ex_op1[u], exp_op1[u]);
                chk("ex_op2", u, ex_op2[u], exp_op2[u]);
                chk("stall_cnt", u, {16'd0, stall_cnt[u]}, 32'(exp_cnt[u]));
            end
        end
    end

    initial begin
        rst = 1'b0;
        for (int u = 0; u < 2; u++) begin
            id_valid[u] = 1'b0; id_src1[u] = 5'd0; id_src2[u] = 5'd0; id_src2_used[u] = 1'b0;
            id_dest[u] = 5'd0; id_wb_en[u] = 1'b0; id_mem_r_en[u] = 1'b0; id_rdata1[u] = 32'd0;
            id_rdata2[u] = 32'd0; flush[u] = 1'b0; id_value[u] = 32'd0;
        end
        model_reset();
        calc();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        chk("rst_ex_valid", 0, {31'd0, ex_valid[0]}, 32'd0);
        chk("rst_ex_op1", 0, ex_op1[0], 32'd0);
        chk("rst_stall_cnt", 1, {16'd0, stall_cnt[1]}, 32'd0);
        chk_en = 1'b1;
        idle(2);

        // Back-to-back ALU: R1 = 5 + 3, then R2 = R1 + R1.
        issue(0, 5'd2, 5'd3, 1'b1, 5'd1, 1'b1, 1'b0, 32'd5, 32'd3, 32'd8, ns);
        chk("alu1_op1", 0, ex_op1[0], 32'd5);
        chk("alu1_op2", 0, ex_op2[0], 32'd3);
        issue(0, 5'd1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b0, 32'hAAAA, 32'hBBBB, 32'd16, ns);
        chk("b2b_stalls", 0, 32'(ns), 32'd0);
        chk("b2b_op1", 0, ex_op1[0], 32'd8);
        chk("b2b_op2", 0, ex_op2[0], 32'd8);
        idle(3);

        // Load-use: LW R4 (0x1234), then R5 = R4 + R0.
        issue(0, 5'd6, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h100, 32'd0, 32'h1234, ns);
        issue(0, 5'd4, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0, 32'hFFFF, 32'd0, 32'h1234, ns);
        chk("lu_stalls", 0, 32'(ns), 32'd1);
        chk("lu_op1", 0, ex_op1[0], 32'h1234);
        chk("lu_op2", 0, ex_op2[0], 32'd0);
        chk("lu_cnt", 0, {16'd0, stall_cnt[0]}, 32'd1);
        idle(3);

        // Double producer of R3, then register and immediate consumers.
        issue(0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 32'd0, 32'd0, 32'd1, ns);
        issue(0, 5'd0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 32'd0, 32'd0, 32'd2, ns);
        issue(0, 5'd3, 5'd3, 1'b1, 5'd7, 1'b1, 1'b0, 32'h111, 32'h222, 32'd4, ns);
        chk("dp_stalls", 0, 32'(ns), 32'd0);
        chk("dp_op1", 0, ex_op1[0], 32'd2);
        chk("dp_op2", 0, ex_op2[0], 32'd2);
        issue(0, 5'd3, 5'd3, 1'b0, 5'd9, 1'b1, 1'b0, 32'h333, 32'h55, 32'd6, ns);
        chk("imm_op1", 0, ex_op1[0], 32'd2);
        chk("imm_op2", 0, ex_op2[0], 32'h55);
        idle(3);

        // Youngest producer is an unready load while an older ALU producer is ready.
        issue(0, 5'd0, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0, 32'd0, 32'd0, 32'd9, ns);
        issue(0, 5'd6, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 32'h40, 32'd0, 32'hABCD, ns);
        issue(0, 5'd8, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0, 32'h1, 32'd0, 32'd0, ns);
        chk("yl_stalls", 0, 32'(ns), 32'd1);
        chk("yl_op1", 0, ex_op1[0], 32'hABCD);
        idle(3);

        // Destination R0 never forwards.
        issue(0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 32'd0, 32'd0, 32'd7, ns);
        issue(0, 5'd0, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0, 32'd0, 32'd0, 32'd0, ns);
        chk("r0_stalls", 0, 32'(ns), 32'd0);
        chk("r0_op1", 0, ex_op1[0], 32'd0);
        idle(3);

        // No-forward instance: consumer of R1 waits until R1 has retired.
        issue(1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd5, ns);
        issue(1, 5'd1, 5'd0, 1'b0, 5'd12, 1'b1, 1'b0, 32'h99, 32'd0, 32'd0, ns);
        chk("nf_stalls", 1, 32'(ns), 32'd3);
        chk("nf_op1", 1, ex_op1[1], 32'h99);
        chk("nf_cnt", 1, {16'd0, stall_cnt[1]}, 32'd3);
        idle(3);

        // Flush while stalled: stall drops and a bubble enters.
        issue(1, 5'd0, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0, 32'd0, 32'd0, 32'd6, ns);
        id_valid[1] = 1'b1; id_src1[1] = 5'd1; id_src2_used[1] = 1'b0; id_dest[1] = 5'd13;
        id_mem_r_en[1] = 1'b0; id_rdata1[1] = 32'h98;
        calc();
        #1;
        chk("fl_pre_stall", 1, {31'd0, stall[1]}, 32'd1);
        flush[1] = 1'b1;
        calc();
        #1;
        chk("fl_stall", 1, {31'd0, stall[1]}, 32'd0);
        @(posedge clk);
        #1;
        advance();
        chk("fl_bubble", 1, {31'd0, ex_valid[1]}, 32'd0);
        flush[1] = 1'b0;
        idle(3);

        // Asynchronous reset in the middle of a load-use stall.
        issue(0, 5'd6, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 32'h200, 32'd0, 32'h4444, ns);
        id_valid[0] = 1'b1; id_src1[0] = 5'd4; id_src2_used[0] = 1'b0; id_dest[0] = 5'd14;
        id_mem_r_en[0] = 1'b0; id_rdata1[0] = 32'h77; id_value[0] = 32'd0;
        calc();
        #1;
        chk("ar_pre_stall", 0, {31'd0, stall[0]}, 32'd1);
        rst = 1'b0;
        #1;
        chk("ar_stall", 0, {31'd0, stall[0]}, 32'd0);
        chk("ar_ex_op1", 0, ex_op1[0], 32'd0);
        chk("ar_ex_op2", 0, ex_op2[0], 32'd0);
        chk("ar_ex_valid", 0, {31'd0, ex_valid[0]}, 32'd0);
        chk("ar_stall_cnt", 0, {16'd0, stall_cnt[0]}, 32'd0);
        chk("ar_stall_cnt", 1, {16'd0, stall_cnt[1]}, 32'd0);
        model_reset();
        calc();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        issue(0, 5'd4, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0, 32'h77, 32'd0, 32'd0, ns);
        chk("ar_post_stalls", 0, 32'(ns), 32'd0);
        chk("ar_post_op1", 0, ex_op1[0], 32'h77);
        idle(2);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
